// File: rtl/otter_mem_arbiter_if.sv
// Bus bundle between the OTTER requesters (data, fetch, loader), the arbiter and main memory.
// Port k of the packed request fields occupies addr/wdata[32k+31:32k] and be[4k+3:4k].
interface otter_mem_arbiter_if;
  logic [2:0]  req;
  logic [2:0]  we;
  logic [95:0] addr;
  logic [95:0] wdata;
  logic [11:0] be;
  logic [2:0]  gnt;
  logic [2:0]  ack;
  logic [31:0] rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        busy;

  // Requesters plus the memory model, as seen from outside the arbiter.
  modport master (
    output req, we, addr, wdata, be, mem_rdata,
    input  gnt, ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy
  );

  modport slave (
    input  req, we, addr, wdata, be, mem_rdata,
    output gnt, ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy
  );
endinterface

// File: rtl/otter_mem_arbiter.sv
// Three-port arbiter for the single-port OTTER main memory: D > I > G priority with fetch
// anti-starvation, one access in flight, fixed read latency MEM_LAT.
module otter_mem_arbiter #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic             clk,
  input logic             rst_n,
  otter_mem_arbiter_if.slave bus
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);
  localparam logic [2:0] WaitInit  = 3'(MEM_LAT - 2);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [3:0]  starve_q, starve_d;
  logic [2:0]  cnt_q, cnt_d;

  logic        arb_en;
  logic        win_vld;
  logic        force_i;
  logic [1:0]  win;
  logic [2:0]  gnt;
  logic [2:0]  ack;
  logic [31:0] rdata;

  // Winner selection; fetch jumps ahead of data once the data port has won StarveMax times.
  always_comb begin
    force_i = (starve_q == StarveMax) && bus.req[1];
    win_vld = |bus.req;
    win     = 2'd0;
    if (bus.req[0] && !force_i) begin
      win = 2'd0;
    end else if (bus.req[1]) begin
      win = 2'd1;
    end else if (bus.req[2]) begin
      win = 2'd2;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    starve_d = starve_q;
    cnt_d    = cnt_q;
    arb_en   = 1'b0;
    gnt      = 3'b000;
    ack      = 3'b000;
    rdata    = 32'h0;

    unique case (state_q)
      StIdle: begin
        arb_en = 1'b1;
      end
      StIssue: begin
        if (MEM_LAT == 1) begin
          state_d = StResp;
        end else begin
          state_d = StWait;
          cnt_d   = WaitInit;
        end
      end
      StWait: begin
        if (cnt_q == 3'd0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StResp: begin
        ack     = 3'b001 << idx_q;
        rdata   = bus.mem_rdata;
        arb_en  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (arb_en && win_vld) begin
      gnt     = 3'b001 << win;
      state_d = StIssue;
      idx_d   = win;
      we_d    = bus.we[win];
      addr_d  = bus.addr[{win, 5'b0} +: 32];
      wdata_d = bus.wdata[{win, 5'b0} +: 32];
      be_d    = bus.be[{win, 2'b0} +: 4];
      unique case (win)
        2'd0: begin
          if (!bus.req[1]) begin
            starve_d = 4'd0;
          end else if (starve_q != StarveMax) begin
            starve_d = starve_q + 4'd1;
          end
        end
        2'd1:    starve_d = 4'd0;
        default: starve_d = starve_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= 2'd0;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      be_q     <= 4'h0;
      starve_q <= 4'd0;
      cnt_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      starve_q <= starve_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.ack       = ack;
  assign bus.rdata     = rdata;
  assign bus.mem_en    = (state_q == StIssue);
  assign bus.mem_we    = we_q && (state_q == StIssue);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Bench for otter_mem_arbiter: vector table, directed corner sequences and a random phase
// checked cycle by cycle against a transaction-schedule model.
module tb_otter_mem_arbiter;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc;
  int   errors;
  int   checks;

  otter_mem_arbiter_if b ();

  otter_mem_arbiter #(
    .MEM_LAT   (MEM_LAT),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b)
  );

  always #5 clk = ~clk;

  // Memory model driven by the DUT's mem_* pins; read data appears MEM_LAT cycles after mem_en.
  bit   [31:0] mem     [256];
  bit   [255:0] written;
  logic [31:0] pipe    [MEM_LAT];

  function automatic logic [31:0] init_word(logic [7:0] i);
    return (i == 8'h40) ? 32'hDEAD_BEEF : {8'hA5, i, ~i, 8'h3C};
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~m) | (wd & m);
  endfunction

  function automatic logic [31:0] mem_rd(logic [7:0] i);
    return written[i] ? mem[i] : init_word(i);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (b.mem_en && b.mem_we) begin
      mem[b.mem_addr[9:2]]     <= merge(mem_rd(b.mem_addr[9:2]), b.mem_wdata, b.mem_be);
      written[b.mem_addr[9:2]] <= 1'b1;
    end
    pipe[0] <= b.mem_en ? mem_rd(b.mem_addr[9:2]) : $urandom;
    for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign b.mem_rdata = pipe[MEM_LAT-1];

  // Requester fields and the reference model state.
  logic [2:0]  p_we;
  logic [31:0] p_addr  [3];
  logic [31:0] p_wdata [3];
  logic [3:0]  p_be    [3];

  bit   [31:0] sh_mem [256];
  bit   [255:0] sh_wr;
  int          last_g = -1000;
  int          m_starve;
  logic [1:0]  m_port;
  logic        m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_be;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic int winner(logic [2:0] r);
    if (r == 3'b000) return -1;
    if (r[0] && !(m_starve == STARVE_MAX && r[1])) return 0;
    if (r[1]) return 1;
    return 2;
  endfunction

  task automatic set_port(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] e);
    p_we[k]    = w;
    p_addr[k]  = a;
    p_wdata[k] = d;
    p_be[k]    = e;
  endtask

  // One clock: drive requests, compare every output against the schedule model, advance it.
  task automatic step(input logic [2:0] r, output logic [2:0] eg, output logic [2:0] dg,
                      output logic [2:0] da, output logic [31:0] drd, output logic dmen);
    int t, w;
    logic [2:0] ea;
    logic emen, ebusy;
    logic [7:0] ix;
    @(posedge clk);
    #1;
    b.req   = r;
    b.we    = p_we;
    b.addr  = {p_addr[2], p_addr[1], p_addr[0]};
    b.wdata = {p_wdata[2], p_wdata[1], p_wdata[0]};
    b.be    = {p_be[2], p_be[1], p_be[0]};
    #3;
    t     = cyc;
    ea    = (t == last_g + MEM_LAT + 1) ? (3'b001 << m_port) : 3'b000;
    emen  = (t == last_g + 1);
    ebusy = (t > last_g) && (t <= last_g + MEM_LAT + 1);
    w     = (t >= last_g + MEM_LAT + 1) ? winner(r) : -1;
    eg    = (w >= 0) ? 3'(1 << w) : 3'b000;
    chk("gnt", b.gnt, eg);
    chk("ack", b.ack, ea);
    chk("mem_en", b.mem_en, emen);
    chk("busy", b.busy, ebusy);
    if (emen) begin
      chk("mem_we", b.mem_we, m_we);
      chk("mem_addr", b.mem_addr, m_addr);
      chk("mem_wdata", b.mem_wdata, m_wdata);
      chk("mem_be", b.mem_be, m_be);
    end
    if (ea != 3'b000 && !m_we) chk("rdata", b.rdata, m_rdata);
    dg   = b.gnt;
    da   = b.ack;
    drd  = b.rdata;
    dmen = b.mem_en;
    if (w >= 0) begin
      if (w == 0) m_starve = r[1] ? ((m_starve < STARVE_MAX) ? m_starve + 1 : m_starve) : 0;
      else if (w == 1) m_starve = 0;
      m_port  = 2'(w);
      m_we    = p_we[w];
      m_addr  = p_addr[w];
      m_wdata = p_wdata[w];
      m_be    = p_be[w];
      ix      = p_addr[w][9:2];
      m_rdata = sh_wr[ix] ? sh_mem[ix] : init_word(ix);
      if (m_we) begin
        sh_mem[ix] = merge(m_rdata, m_wdata, m_be);
        sh_wr[ix]  = 1'b1;
      end
      last_g = t;
    end
  endtask

  task automatic do_reset(input bit mid);
    b.req = 3'b000;
    if (mid) begin
      @(posedge clk);
      #2;
    end
    rst_n = 1'b0;
    #1;
    chk("rst_busy", b.busy, 1'b0);
    chk("rst_mem_en", b.mem_en, 1'b0);
    chk("rst_ack", b.ack, 3'b000);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_gnt", b.gnt, 3'b000);
    chk("rst_ack_hold", b.ack, 3'b000);
    chk("rst_busy_hold", b.busy, 1'b0);
    chk("rst_mem_we", b.mem_we, 1'b0);
    chk("rst_mem_addr", b.mem_addr, 32'h0);
    chk("rst_mem_wdata", b.mem_wdata, 32'h0);
    chk("rst_mem_be", b.mem_be, 4'h0);
    chk("rst_rdata", b.rdata, 32'h0);
    rst_n    = 1'b1;
    last_g   = -1000;
    m_starve = 0;
  endtask

  logic [2:0]  eg, dg, da, last_eg, pend;
  logic [31:0] drd;
  logic        dmen;
  int          gq[$];

  task automatic idle(input int n);
    repeat (n) step(3'b000, eg, dg, da, drd, dmen);
  endtask

  // Hold r until n grants have been seen (bounded), recording the granted port numbers.
  task automatic collect(input logic [2:0] r, input int n);
    gq.delete();
    for (int i = 0; i < 40 * n && gq.size() < n; i++) begin
      step(r, eg, dg, da, drd, dmen);
      if (dg != 3'b000) gq.push_back(dg == 3'b001 ? 0 : dg == 3'b010 ? 1 : dg == 3'b100 ? 2 : 9);
    end
    chk("grant_count", gq.size(), n);
  endtask

  typedef struct {
    logic [2:0]  req;
    logic [31:0] addr;
    logic [2:0]  exp_gnt;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vt[7];

  initial begin
    vt[0] = '{3'b001, 32'h0000_0100, 3'b001, 32'hDEAD_BEEF};
    vt[1] = '{3'b010, 32'h0000_0104, 3'b010, 32'hA541_BE3C};
    vt[2] = '{3'b100, 32'h0000_0108, 3'b100, 32'hA542_BD3C};
    vt[3] = '{3'b011, 32'h0000_010C, 3'b001, 32'hA543_BC3C};
    vt[4] = '{3'b110, 32'h0000_0110, 3'b010, 32'hA544_BB3C};
    vt[5] = '{3'b101, 32'h0000_0114, 3'b001, 32'hA545_BA3C};
    vt[6] = '{3'b111, 32'h0000_0118, 3'b001, 32'hA546_B93C};
    for (int k = 0; k < 3; k++) set_port(k, 1'b0, 32'h0, 32'h0, 4'hF);
    b.we = 3'b000; b.addr = '0; b.wdata = '0; b.be = '0;
    do_reset(1'b0);

    // Single transactions from idle: winner, ack timing and read data.
    foreach (vt[i]) begin
      for (int k = 0; k < 3; k++) set_port(k, 1'b0, vt[i].addr, 32'h0, 4'hF);
      step(vt[i].req, eg, dg, da, drd, dmen);
      chk("tbl_gnt", dg, vt[i].exp_gnt);
      idle(MEM_LAT);
      step(3'b000, eg, dg, da, drd, dmen);
      chk("tbl_ack", da, vt[i].exp_gnt);
      chk("tbl_rdata", drd, vt[i].exp_rdata);
    end

    // All three requesting: D four times, then fetch forced; then I, then G.
    do_reset(1'b0);
    for (int k = 0; k < 3; k++) set_port(k, 1'b0, 32'h40 + 32'(k * 4), 32'h0, 4'hF);
    collect(3'b111, 5);
    for (int i = 0; i < gq.size(); i++) chk("all3_order", gq[i], (i == 4) ? 1 : 0);
    collect(3'b110, 1);
    if (gq.size() > 0) chk("i_over_g", gq[0], 1);
    collect(3'b100, 1);
    if (gq.size() > 0) chk("g_last", gq[0], 2);

    // Continuous D and I: fetch wins every fifth grant.
    collect(3'b011, 20);
    for (int i = 0; i < gq.size(); i++) chk("starve_order", gq[i], (i % 5 == 4) ? 1 : 0);
    idle(MEM_LAT + 2);

    // Fetch re-requests in its own ack cycle.
    set_port(1, 1'b0, 32'h0000_0180, 32'h0, 4'hF);
    step(3'b010, eg, dg, da, drd, dmen);
    chk("b2b_gnt0", dg, 3'b010);
    idle(MEM_LAT);
    step(3'b010, eg, dg, da, drd, dmen);
    chk("b2b_ack", da, 3'b010);
    chk("b2b_gnt1", dg, 3'b010);
    step(3'b000, eg, dg, da, drd, dmen);
    chk("b2b_mem_en", dmen, 1'b1);
    idle(MEM_LAT + 1);

    // Loader write with partial byte enables, then read it back through the data port.
    set_port(2, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'b0011);
    step(3'b100, eg, dg, da, drd, dmen);
    chk("wr_gnt", dg, 3'b100);
    step(3'b000, eg, dg, da, drd, dmen);
    chk("wr_mem_en", dmen, 1'b1);
    chk("wr_mem_we", b.mem_we, 1'b1);
    chk("wr_mem_be", b.mem_be, 4'b0011);
    chk("wr_mem_wdata", b.mem_wdata, 32'h1234_5678);
    idle(MEM_LAT - 1);
    step(3'b000, eg, dg, da, drd, dmen);
    chk("wr_ack", da, 3'b100);
    set_port(2, 1'b0, 32'h0, 32'h0, 4'hF);
    set_port(0, 1'b0, 32'h0000_0200, 32'h0, 4'hF);
    step(3'b001, eg, dg, da, drd, dmen);
    idle(MEM_LAT);
    step(3'b000, eg, dg, da, drd, dmen);
    chk("wr_readback", drd, 32'hA580_5678);

    // Reset pulled during WAIT: access abandoned, next grant is fresh.
    set_port(0, 1'b0, 32'h0000_0104, 32'h0, 4'hF);
    step(3'b001, eg, dg, da, drd, dmen);
    step(3'b000, eg, dg, da, drd, dmen);
    do_reset(1'b1);
    set_port(1, 1'b0, 32'h0000_0108, 32'h0, 4'hF);
    step(3'b010, eg, dg, da, drd, dmen);
    chk("post_rst_gnt", dg, 3'b010);
    idle(MEM_LAT + 1);

    // Random requesters following the hold-until-grant contract, with occasional withdrawal.
    pend    = 3'b000;
    last_eg = 3'b000;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (pend[k] && last_eg[k]) begin
          pend[k] = 1'b0;
        end else if (pend[k] && $urandom_range(0, 49) == 0) begin
          pend[k] = 1'b0;
        end
        if (!pend[k] && $urandom_range(0, 3) == 0) begin
          pend[k] = 1'b1;
          set_port(k, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
        end
      end
      step(pend, eg, dg, da, drd, dmen);
      last_eg = eg;
    end
    idle(MEM_LAT + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
